apb_master: RTL and testbench

- APB3 master bridging the CPU's simple load/store bus to up to four APB slaves (RAM, GPIO, UART, timer).
- Each slave occupies one 4 KB window.
- Sequences each transfer through IDLE/SETUP/ACCESS and decodes the address to a one-hot PSEL.
- Muxes the selected slave's PRDATA/PREADY back to the CPU.
- Reports an error for decode misses and for slaves that stall beyond a timeout.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_decoder.sv | 34 +++
 rtl/apb_master.sv | 189 ++++++++++++++++++
 tb/tb_apb_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg: shared definitions for the APB3 master and its address decoder.
//   - apb_state_e   : transfer sequencing states
//   - N_SLV         : number of APB slave windows
//   - WIN_MASK      : byte-offset mask inside one 4 KB slave window
//   - DEF_BASE_ADDR : default base of the peripheral region
//   - idx_to_onehot : slave index -> one-hot PSEL pattern
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int          N_SLV         = 4;
    localparam logic [11:0] WIN_MASK      = 12'hFFF;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;

    function automatic logic [N_SLV-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [N_SLV-1:0] one;
        one = {{(N_SLV-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/apb_decoder.sv
// ---------------------------------------------------------------------------
// apb_decoder: combinational decode of a CPU address page to an APB slave.
// Ports:
//   addr_page  in  20  address bits [31:12] (offset bits are not needed)
//   hit        out 1   address lies inside the four-window peripheral region
//   idx        out 2   slave index (address bits [13:12])
//   sel_onehot out 4   one-hot slave select, all zero on a miss
// ---------------------------------------------------------------------------
module apb_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic [19:0]      addr_page,
    output logic             hit,
    output logic [1:0]       idx,
    output logic [N_SLV-1:0] sel_onehot
);

    // The region spans 4 x 4 KB, so only bits [31:14] identify it.
    localparam logic [17:0] BASE_HI = BASE_ADDR[31:14];

    // Region compare and one-hot select generation
    always_comb begin
        hit = (addr_page[19:2] == BASE_HI);
        idx = addr_page[1:0];
        if (hit) begin
            sel_onehot = idx_to_onehot(addr_page[1:0]);
        end else begin
            sel_onehot = {N_SLV{1'b0}};
        end
    end

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master: APB3 master bridging a simple CPU load/store bus to four slaves.
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   transfer/write/addr/wdata  CPU request (transfer sampled only in IDLE)
//   rdata/ready/err         CPU completion: one-cycle ready pulse, err flag,
//                           read data held until the next completion
//   PADDR/PWDATA/PWRITE     APB address offset, write data, direction
//   PENABLE/PSEL            APB access phase and one-hot slave select
//   PRDATA0..3/PREADY0..3   per-slave read data and ready
// All outputs are registered.
// ---------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          TIMEOUT   = 16,
    parameter int          CNT_W     = 5
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [11:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    // Last ACCESS cycle count at which a missing PREADY forces an error.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e       state_r, state_s;
    logic [3:0]       psel_r, psel_s;
    logic             penable_r, penable_s;
    logic             pwrite_r, pwrite_s;
    logic [11:0]      paddr_r, paddr_s;
    logic [31:0]      pwdata_r, pwdata_s;
    logic [31:0]      rdata_r, rdata_s;
    logic             ready_r, ready_s;
    logic             err_r, err_s;
    logic [1:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic             hit_s;
    logic [1:0]       dec_idx_s;
    logic [3:0]       dec_sel_s;
    logic             pready_sel_s;
    logic [31:0]      prdata_sel_s;

    apb_decoder #(
        .BASE_ADDR (BASE_ADDR)
    ) u_dec (
        .addr_page  (addr[31:12]),
        .hit        (hit_s),
        .idx        (dec_idx_s),
        .sel_onehot (dec_sel_s)
    );

    // Return-path mux: only the registered slave index is ever looked at
    always_comb begin
        case (idx_r)
            2'd0: begin pready_sel_s = PREADY0; prdata_sel_s = PRDATA0; end
            2'd1: begin pready_sel_s = PREADY1; prdata_sel_s = PRDATA1; end
            2'd2: begin pready_sel_s = PREADY2; prdata_sel_s = PRDATA2; end
            2'd3: begin pready_sel_s = PREADY3; prdata_sel_s = PRDATA3; end
            default: begin pready_sel_s = 1'b0; prdata_sel_s = 32'h0; end
        endcase
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer
    always_comb begin
        state_s   = state_r;
        psel_s    = psel_r;
        penable_s = penable_r;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        rdata_s   = rdata_r;
        ready_s   = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (transfer) begin
                    paddr_s  = addr[11:0] & WIN_MASK;
                    pwdata_s = wdata;
                    pwrite_s = write;
                    idx_s    = dec_idx_s;
                    if (hit_s) begin
                        state_s = SETUP;
                        psel_s  = dec_sel_s;
                    end else begin
                        // Decode miss completes immediately without touching the bus.
                        ready_s = 1'b1;
                        err_s   = 1'b1;
                        rdata_s = 32'h0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s   = ACCESS;
                penable_s = 1'b1;
            end
            ACCESS: begin
                if (pready_sel_s) begin
                    state_s   = IDLE;
                    psel_s    = 4'b0000;
                    penable_s = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    ready_s   = 1'b1;
                    rdata_s   = pwrite_r ? 32'h0 : prdata_sel_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    psel_s    = 4'b0000;
                    penable_s = 1'b0;
                    cnt_s     = {CNT_W{1'b0}};
                    ready_s   = 1'b1;
                    err_s     = 1'b1;
                    rdata_s   = 32'h0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s   = IDLE;
                psel_s    = 4'b0000;
                penable_s = 1'b0;
                cnt_s     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= IDLE;
            psel_r    <= 4'b0000;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= 12'h000;
            pwdata_r  <= 32'h0;
            idx_r     <= 2'd0;
            cnt_r     <= {CNT_W{1'b0}};
            rdata_r   <= 32'h0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            idx_r     <= idx_s;
            cnt_r     <= cnt_s;
            rdata_r   <= rdata_s;
            ready_r   <= ready_s;
            err_r     <= err_s;
        end
    end

    assign PSEL    = psel_r;
    assign PENABLE = penable_r;
    assign PWRITE  = pwrite_r;
    assign PADDR   = paddr_r;
    assign PWDATA  = pwdata_r;
    assign rdata   = rdata_r;
    assign ready   = ready_r;
    assign err     = err_r;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master: self-checking bench for apb_master.
// Four behavioural APB slaves with per-slave PREADY latency (registered,
// held one stale cycle after completion) drive the DUT. Expectations come
// from a vector table and from a transaction-level model of the bridge.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int          TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Slave models
    bit [31:0] smem [4][1024];
    bit [31:0] sdata [4];
    bit        srdy [4];
    int        wcnt [4];
    int        hold [4];
    int        lat  [4];
    bit        force_rdy3 = 1'b0;

    // Reference memory of the whole peripheral region, keyed by CPU address
    logic [31:0] ref_mem [logic [31:0]];

    always #5 PCLK = ~PCLK;

    apb_master #(.BASE_ADDR(BASE), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL(PSEL),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    assign PRDATA0 = sdata[0];
    assign PRDATA1 = sdata[1];
    assign PRDATA2 = sdata[2];
    assign PRDATA3 = sdata[3];
    assign PREADY0 = srdy[0];
    assign PREADY1 = srdy[1];
    assign PREADY2 = srdy[2];
    assign PREADY3 = srdy[3] | force_rdy3;

    // Slave behaviour: after lat[i] waited ACCESS cycles raise a registered
    // PREADY for the completing cycle plus one stale cycle; 255 = never.
    always @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (hold[i] > 0) begin
                hold[i] <= hold[i] - 1;
                srdy[i] <= (hold[i] > 1);
                wcnt[i] <= 0;
            end else if (PSEL[i] && PENABLE) begin
                if (wcnt[i] == lat[i]) begin
                    srdy[i]  <= 1'b1;
                    hold[i]  <= 2;
                    sdata[i] <= smem[i][PADDR[11:2]];
                    if (PWRITE) smem[i][PADDR[11:2]] <= PWDATA;
                end else begin
                    wcnt[i] <= wcnt[i] + 1;
                end
            end else begin
                wcnt[i] <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h0000_4000);
    endfunction

    function automatic int slave_of(input logic [31:0] a);
        return int'((a - BASE) >> 12);
    endfunction

    // Model: completion cycle counted from the transfer cycle (cycle 0)
    function automatic int model_cycles(input logic [31:0] a);
        if (!is_hit(a)) return 1;
        if (lat[slave_of(a)] <= TIMEOUT - 2) return 4 + lat[slave_of(a)];
        return 2 + TIMEOUT;
    endfunction

    function automatic bit model_ok(input logic [31:0] a);
        return is_hit(a) && (lat[slave_of(a)] <= TIMEOUT - 2);
    endfunction

    // One CPU transfer starting at a negedge; returns the observed completion.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output bit e, output logic [31:0] rd);
        bit hit;
        int s, pcnt, exp_p;
        hit  = is_hit(a);
        s    = hit ? slave_of(a) : 0;
        exp_p = !hit ? 0 : (model_ok(a) ? lat[s] + 3 : TIMEOUT + 1);
        transfer = 1'b1; write = wr; addr = a; wdata = d;
        cyc = 0; e = 1'b0; rd = 32'h0; pcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                transfer = 1'b0;
                write = $urandom_range(0, 1);
                addr  = $urandom;
                wdata = $urandom;
            end
            if (PSEL != 4'b0000) pcnt++;
            if (hit && c == 1) begin
                chk("setup_psel", {28'h0, PSEL}, 32'(1) << s);
                chk("setup_penable", {31'h0, PENABLE}, 32'h0);
            end
            if (hit && c == 2) begin
                chk("access_penable", {31'h0, PENABLE}, 32'h1);
                chk("access_paddr", {20'h0, PADDR}, {20'h0, a[11:0]});
                chk("access_pwrite", {31'h0, PWRITE}, {31'h0, wr});
                chk("access_pwdata", PWDATA, d);
            end
            if (ready) begin
                cyc = c; e = err; rd = rdata;
                break;
            end
        end
        if (cyc == 0) begin
            total_cnt++;
            $display("FAIL ready_bound: no ready within 40 cycles for addr %h", a);
        end else begin
            chk("psel_cleared", {28'h0, PSEL}, 32'h0);
            chk("psel_cycles", pcnt, exp_p);
        end
        if (wr && model_ok(a)) ref_mem[a] = d;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          l;
        int          cyc;
        bit          e;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cyc;
        bit e;
        logic [31:0] rd, exp_rd, a, d;
        bit wr;
        int seen;

        for (int i = 0; i < 4; i++) lat[i] = 0;
        vecs[0]  = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 0,   4,  1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h1000_0010, 32'h0,         0,   4,  1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h1000_0010, 32'h0,         0,   4,  1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h2000_0000, 32'h0,         0,   1,  1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h1000_1008, 32'hCAFE_F00D, 2,   6,  1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h1000_1008, 32'h0,         2,   6,  1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 32'h1000_3FFC, 32'h1234_5678, 14,  18, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h1000_3FFC, 32'h0,         15,  18, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 32'h1000_3FFC, 32'h0,         0,   4,  1'b0, 32'h1234_5678};
        vecs[9]  = '{1'b0, 32'h1000_4000, 32'h0,         0,   1,  1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         0,   1,  1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h1000_2004, 32'h0,         255, 18, 1'b1, 32'h0};

        // Reset state
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", {28'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_paddr", {20'h0, PADDR}, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Table-driven vectors (consecutive entries run back-to-back)
        for (int i = 0; i < 12; i++) begin
            if (is_hit(vecs[i].a)) lat[slave_of(vecs[i].a)] = vecs[i].l;
            xfer(vecs[i].wr, vecs[i].a, vecs[i].d, cyc, e, rd);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].e});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
        end

        // ready is a single-cycle pulse and rdata holds
        lat[0] = 1;
        xfer(1'b0, 32'h1000_0010, 32'h0, cyc, e, rd);
        chk("hold_pre_rdata", rd, 32'hDEAD_BEEF);
        @(negedge PCLK);
        chk("ready_pulse_width", {31'h0, ready}, 32'h0);
        chk("err_pulse_width", {31'h0, err}, 32'h0);
        chk("rdata_hold", rdata, 32'hDEAD_BEEF);

        // Reset during ACCESS on slave 1 aborts with no completion
        lat[1] = 10;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1008;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_reset_access", {27'h0, PENABLE, PSEL}, {27'h0, 1'b1, 4'b0010});
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", {28'h0, PSEL}, 32'h0);
        chk("mid_rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        PRESET = 1'b0;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge PCLK);
            if (ready || PSEL != 4'b0000) seen++;
        end
        chk("no_abort_activity", seen, 0);
        lat[1] = 0;
        xfer(1'b0, 32'h1000_1008, 32'h0, cyc, e, rd);
        chk("post_rst_cycles", cyc, 4);
        chk("post_rst_rdata", rd, 32'hCAFE_F00D);

        // Slave isolation: PREADY3 stuck high while slave 1 answers late
        force_rdy3 = 1'b1;
        lat[1] = 3;
        xfer(1'b1, 32'h1000_1010, 32'h5A5A_1111, cyc, e, rd);
        chk("iso_wr_cycles", cyc, 7);
        chk("iso_wr_err", {31'h0, e}, 32'h0);
        xfer(1'b0, 32'h1000_1010, 32'h0, cyc, e, rd);
        chk("iso_rd_cycles", cyc, 7);
        chk("iso_rd_rdata", rd, 32'h5A5A_1111);
        force_rdy3 = 1'b0;

        // Randomized transfers against the transaction-level model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] off;
            int s;
            off = {20'h0, 7'h0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: a = 32'h2000_0000 + off;
                    1: a = 32'h1000_4000 + off;
                    default: a = 32'h0FFF_F000 + off;
                endcase
            end else begin
                s = $urandom_range(0, 3);
                a = BASE + (32'(s) << 12) + off;
                case ($urandom_range(0, 9))
                    7: lat[s] = 14;
                    8: lat[s] = 255;
                    9: lat[s] = 1;
                    default: lat[s] = $urandom_range(0, 6);
                endcase
            end
            wr = $urandom_range(0, 1);
            d  = $urandom;
            exp_rd = 32'h0;
            if (!wr && model_ok(a) && ref_mem.exists(a)) exp_rd = ref_mem[a];
            xfer(wr, a, d, cyc, e, rd);
            chk($sformatf("rnd%0d_cycles", n), cyc, model_cycles(a));
            chk($sformatf("rnd%0d_err", n), {31'h0, e}, {31'h0, !model_ok(a)});
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
        end

        @(negedge PCLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
